// File: rtl/dmem_access_ctrl.sv
// Load/store initiator for the 32-word data memory: byte-lane extract on loads,
// read-modify-write for byte stores, single outstanding request.
module dmem_access_ctrl #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [AW+1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_data,
  output logic          resp_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, DONE} state_t;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_SW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;

  state_t        state, state_nxt;
  logic [2:0]    op_q;
  logic [1:0]    off_q;
  logic [7:0]    wbyte_q;
  logic          accept;
  logic          op_legal;
  logic          req_bad;
  logic [7:0]    lane_byte;
  logic [DW-1:0] load_result;
  logic [DW-1:0] merged_word;

  // Byte lanes are big-endian: offset 0 is bits 31:24.
  function automatic logic [7:0] lane_get(input logic [DW-1:0] w, input logic [1:0] off);
    case (off)
      2'd0:    lane_get = w[31:24];
      2'd1:    lane_get = w[23:16];
      2'd2:    lane_get = w[15:8];
      default: lane_get = w[7:0];
    endcase
  endfunction

  function automatic logic [DW-1:0] lane_put(input logic [DW-1:0] w, input logic [1:0] off,
                                             input logic [7:0] b);
    lane_put = w;
    case (off)
      2'd0:    lane_put[31:24] = b;
      2'd1:    lane_put[23:16] = b;
      2'd2:    lane_put[15:8]  = b;
      default: lane_put[7:0]   = b;
    endcase
  endfunction

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign accept     = req_valid & req_ready;

  assign op_legal = (req_op == OP_LW) || (req_op == OP_LB) || (req_op == OP_LBU) ||
                    (req_op == OP_SW) || (req_op == OP_SB);
  assign req_bad  = !op_legal ||
                    (((req_op == OP_LW) || (req_op == OP_SW)) && (req_addr[1:0] != 2'b00));

  // NOTE: every output of an always_comb block gets a default first so that no
  // path through the case statement leaves it unassigned and infers a latch.
  always_comb begin
    lane_byte   = lane_get(mem_rdata, off_q);
    merged_word = lane_put(mem_rdata, off_q, wbyte_q);
    load_result = '0;
    case (op_q)
      OP_LW:   load_result = mem_rdata;
      OP_LB:   load_result = {{(DW-8){lane_byte[7]}}, lane_byte};
      OP_LBU:  load_result = {{(DW-8){1'b0}}, lane_byte};
      default: load_result = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_bad) begin
            state_nxt = DONE;
          end else begin
            case (req_op)
              OP_SW:   state_nxt = WR;
              OP_SB:   state_nxt = RMW_RD;
              default: state_nxt = RD;
            endcase
          end
        end
      end
      RD:      state_nxt = DONE;
      WR:      state_nxt = DONE;
      RMW_RD:  state_nxt = RMW_WR;
      RMW_WR:  state_nxt = DONE;
      DONE:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // mem_we lives in a register with async reset so a reset drops it at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      off_q     <= '0;
      wbyte_q   <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= req_op;
            off_q     <= req_addr[1:0];
            wbyte_q   <= req_wdata[7:0];
            mem_addr  <= req_addr[AW+1:2];
            resp_data <= '0;
            resp_err  <= req_bad;
            if (!req_bad && (req_op == OP_SW)) begin
              mem_we    <= 1'b1;
              mem_wdata <= req_wdata;
            end
          end
        end
        RD:     resp_data <= load_result;
        WR:     mem_we    <= 1'b0;
        RMW_RD: begin
          mem_wdata <= merged_word;
          mem_we    <= 1'b1;
        end
        RMW_WR: mem_we    <= 1'b0;
        DONE: begin
          if (resp_ready) begin
            resp_err  <= 1'b0;
            resp_data <= '0;
          end
        end
        default: mem_we   <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: table of load/store vectors against a
// behavioural 32-word memory, plus hand sequences for backpressure and reset.
module tb_dmem_access_ctrl;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [AW+1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_data;
  logic          resp_err;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  dmem_access_ctrl #(.AW(AW), .DW(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: word i starts at i*4, writes land on the falling edge.
  logic [31:0] mem [32];
  bit          mem_init_done = 1'b0;
  int          we_cnt = 0;
  time         we_time = 0;
  logic [AW-1:0] we_addr = '0;

  always @(negedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'(i * 4);
      mem_init_done = 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] = mem_wdata;
      we_cnt  = we_cnt + 1;
      we_time = $time;
      we_addr = mem_addr;
    end
  end

  assign mem_rdata = mem[mem_addr];

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
    int          exp_dt;
  } vec_t;

  // One complete transaction from request to response handshake.
  task automatic run_req(input string tag, input logic [2:0] op, input logic [6:0] addr,
                         input logic [31:0] wd, input int hold, input logic [31:0] exp_data,
                         input logic exp_err, input int exp_lat, input int exp_we,
                         input int exp_dt);
    time t_acc;
    int  we0;
    int  lat;
    check({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    t_acc = $time;
    we0   = we_cnt;
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " data"}, resp_data, exp_data);
    check({tag, " err"}, 32'(resp_err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      @(posedge clk); #1;
      check({tag, " hold valid"}, 32'(resp_valid), 32'd1);
      check({tag, " hold data"}, resp_data, exp_data);
      check({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, " valid after hs"}, 32'(resp_valid), 32'd0);
    check({tag, " idle after hs"}, 32'(req_ready), 32'd1);
    check({tag, " writes"}, 32'(we_cnt - we0), 32'(exp_we));
    if (exp_we > 0) begin
      check({tag, " write time"}, 32'(we_time - t_acc), 32'(exp_dt));
      check({tag, " write addr"}, 32'(we_addr), 32'(addr[6:2]));
    end
  endtask

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{3'b100, 7'h14, 32'h128534F0, 32'h0,        1'b0, 2, 1, 5};
    vecs[1]  = '{3'b001, 7'h15, 32'h0,        32'hFFFFFF85, 1'b0, 2, 0, 0};
    vecs[2]  = '{3'b010, 7'h15, 32'h0,        32'h00000085, 1'b0, 2, 0, 0};
    vecs[3]  = '{3'b001, 7'h17, 32'h0,        32'hFFFFFFF0, 1'b0, 2, 0, 0};
    vecs[4]  = '{3'b001, 7'h14, 32'h0,        32'h00000012, 1'b0, 2, 0, 0};
    vecs[5]  = '{3'b000, 7'h14, 32'h0,        32'h128534F0, 1'b0, 2, 0, 0};
    vecs[6]  = '{3'b101, 7'h16, 32'h000000AB, 32'h0,        1'b0, 3, 1, 15};
    vecs[7]  = '{3'b000, 7'h14, 32'h0,        32'h1285ABF0, 1'b0, 2, 0, 0};
    vecs[8]  = '{3'b000, 7'h15, 32'h0,        32'h0,        1'b1, 1, 0, 0};
    vecs[9]  = '{3'b100, 7'h06, 32'hDEADBEEF, 32'h0,        1'b1, 1, 0, 0};
    vecs[10] = '{3'b111, 7'h14, 32'hCAFEF00D, 32'h0,        1'b1, 1, 0, 0};
    vecs[11] = '{3'b000, 7'h14, 32'h0,        32'h1285ABF0, 1'b0, 2, 0, 0};
    vecs[12] = '{3'b000, 7'h04, 32'h0,        32'h00000004, 1'b0, 2, 0, 0};

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_op     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_data", resp_data, 32'd0);
    check("reset resp_err", 32'(resp_err), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset mem_addr", 32'(mem_addr), 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      run_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata, 0,
              vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_we,
              vecs[i].exp_dt);
    end

    // Backpressure: response held three cycles, stray req_valid ignored.
    run_req("lw_hold", 3'b000, 7'h08, 32'h0, 3, 32'h00000008, 1'b0, 2, 0, 0);

    // Reset during RMW_RD of a byte store: no write, pending response dropped.
    begin
      int we0;
      we0 = we_cnt;
      req_valid = 1'b1;
      req_op    = 3'b101;
      req_addr  = 7'h14;
      req_wdata = 32'h000000FF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst mid req_ready", 32'(req_ready), 32'd1);
      check("rst mid resp_valid", 32'(resp_valid), 32'd0);
      check("rst mid mem_we", 32'(mem_we), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst mid no write", 32'(we_cnt - we0), 32'd0);
      check("rst mid still idle", 32'(resp_valid), 32'd0);
    end
    run_req("lw_after_rst", 3'b000, 7'h14, 32'h0, 0, 32'h1285ABF0, 1'b0, 2, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
